bcd_decade_sequencer: RTL and testbench

//   Sequences the 4-bit BCD decimal decoder: a prescaled, up/down decade counter whose

---
 rtl/bcd_decade_sequencer_if.sv | 41 ++++
 rtl/bcd_decade_sequencer.sv | 141 ++++++++++++++
 tb/tb_bcd_decade_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/bcd_decade_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_decade_sequencer_if
//  Description : Control/status bundle between the board switches/buttons and
//                the BCD decade sequencer.
//                - The master side drives the control inputs and reads the
//                  decoder-facing outputs.
//                - The slave side is the sequencer itself.
//  Revision    : 1.0 - initial release
// ============================================================================
interface bcd_decade_sequencer_if;
    // Control inputs into the sequencer
    logic       start;
    logic       stop;
    logic       load;
    logic [3:0] load_val;
    logic       up_dn;

    // Decoder-facing outputs from the sequencer
    logic       bcd_a;
    logic       bcd_b;
    logic       bcd_c;
    logic       bcd_d;
    logic [9:0] dec;

    // Status outputs from the sequencer
    logic       carry;
    logic       err;
    logic       running;

    modport master (
        output start, stop, load, load_val, up_dn,
        input  bcd_a, bcd_b, bcd_c, bcd_d, dec, carry, err, running
    );

    modport slave (
        input  start, stop, load, load_val, up_dn,
        output bcd_a, bcd_b, bcd_c, bcd_d, dec, carry, err, running
    );
endinterface
`default_nettype wire

// File: rtl/bcd_decade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_decade_sequencer
//  Description : Prescaled up/down decade counter for a 4-bit BCD decimal
//                decoder.
//                - Drives the decoder A..D lines from the count.
//                - Drives a registered one-hot decimal bus.
//                - Emits a carry pulse on wrap so that digits can be
//                  cascaded.
//                - IDLE/RUN/PAUSE control with start/stop buttons.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_decade_sequencer #(
    parameter int DIV = 4,  // clock cycles per count step, 1..2**PW
    parameter int PW  = 8   // prescaler width
) (
    input  wire logic             clk,
    input  wire logic             rst,
    bcd_decade_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    // Prescaler value on which a count step is taken
    localparam logic [PW-1:0] c_PRESC_LAST = PW'(DIV - 1);
    localparam logic [3:0]    c_MAX_DIGIT  = 4'd9;

    state_t          state_q,   state_d;
    logic [PW-1:0]   presc_q,   presc_d;
    logic [3:0]      count_q,   count_d;
    logic [9:0]      dec_q,     dec_d;
    logic            carry_q,   carry_d;
    logic            err_q,     err_d;
    logic            running_q, running_d;
    logic            w_step;

    // Next-state logic: FSM transitions, prescaler, step/load and output decode
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        carry_d   = 1'b0;
        err_d     = 1'b0;
        w_step    = 1'b0;

        case (state_q)
            ST_IDLE, ST_PAUSE: begin
                // stop vetoes start so that holding both keeps the counter parked
                if (bus.start && !bus.stop) begin
                    state_d = ST_RUN;
                    presc_d = '0;
                end
            end
            ST_RUN: begin
                // The cycle that leaves RUN neither advances the prescaler nor steps
                if (bus.stop) begin
                    state_d = ST_PAUSE;
                end else if (presc_q == c_PRESC_LAST) begin
                    presc_d = '0;
                    w_step  = 1'b1;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase

        // A load overrides any coincident step; an illegal value freezes count and prescaler
        if (bus.load) begin
            if (bus.load_val <= c_MAX_DIGIT) begin
                count_d = bus.load_val;
                presc_d = '0;
            end else begin
                err_d   = 1'b1;
                presc_d = presc_q;
            end
        end else if (w_step) begin
            if (bus.up_dn) begin
                if (count_q >= c_MAX_DIGIT) begin
                    count_d = 4'd0;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q + 4'd1;
                end
            end else begin
                if (count_q == 4'd0) begin
                    count_d = c_MAX_DIGIT;
                    carry_d = 1'b1;
                end else begin
                    count_d = count_q - 4'd1;
                end
            end
        end

        running_d = (state_d == ST_RUN);

        // Decode from the next count so dec and the A..D lines change on the same edge
        for (int n = 0; n < 10; n++) begin
            dec_d[n] = (count_d == 4'(n));
        end
    end

    // State and registered outputs; synchronous reset overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            count_q   <= 4'd0;
            dec_q     <= 10'b00_0000_0001;
            carry_q   <= 1'b0;
            err_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            dec_q     <= dec_d;
            carry_q   <= carry_d;
            err_q     <= err_d;
            running_q <= running_d;
        end
    end

    assign bus.bcd_a   = count_q[3];
    assign bus.bcd_b   = count_q[2];
    assign bus.bcd_c   = count_q[1];
    assign bus.bcd_d   = count_q[0];
    assign bus.dec     = dec_q;
    assign bus.carry   = carry_q;
    assign bus.err     = err_q;
    assign bus.running = running_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_decade_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_decade_sequencer
//  Description : Directed self-checking bench for bcd_decade_sequencer.
//                - Expected digit and pulse values are queued as stimulus is
//                  applied.
//                - They are popped and compared one cycle later.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_decade_sequencer;

    typedef struct packed {
        logic [3:0] cnt;
        logic       carry;
        logic       err;
        logic       run;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    bcd_decade_sequencer_if u_if ();

    bcd_decade_sequencer #(
        .DIV (4),
        .PW  (8)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop one expectation and compare every output against it
    task automatic check(input string tag);
        exp_t       e;
        logic [3:0] obs_cnt;
        logic [9:0] exp_dec;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: no expectation queued (observed output, required queue entry)", tag);
            return;
        end
        e       = sb_q.pop_front();
        obs_cnt = {u_if.bcd_a, u_if.bcd_b, u_if.bcd_c, u_if.bcd_d};
        exp_dec = 10'd1 << e.cnt;

        checks++;
        assert (obs_cnt === e.cnt) else begin
            errors++;
            $error("FAIL %s count: observed %0d expected %0d", tag, obs_cnt, e.cnt);
        end
        checks++;
        assert (u_if.dec === exp_dec) else begin
            errors++;
            $error("FAIL %s dec: observed %h expected %h", tag, u_if.dec, exp_dec);
        end
        checks++;
        assert (u_if.carry === e.carry) else begin
            errors++;
            $error("FAIL %s carry: observed %b expected %b", tag, u_if.carry, e.carry);
        end
        checks++;
        assert (u_if.err === e.err) else begin
            errors++;
            $error("FAIL %s err: observed %b expected %b", tag, u_if.err, e.err);
        end
        checks++;
        assert (u_if.running === e.run) else begin
            errors++;
            $error("FAIL %s running: observed %b expected %b", tag, u_if.running, e.run);
        end
    endtask

    // Queue the expectation for the coming edge, clock once, then compare
    task automatic cyc(input string tag, input logic [3:0] c, input logic cy,
                       input logic e, input logic r);
        exp_t x;
        x.cnt   = c;
        x.carry = cy;
        x.err   = e;
        x.run   = r;
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        check(tag);
    endtask

    // Bounded run time: never hang
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] exp_cnt;
        logic       exp_cy;

        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        u_if.start    = 1'b1;
        u_if.stop     = 1'b0;
        u_if.load     = 1'b0;
        u_if.load_val = 4'd0;
        u_if.up_dn    = 1'b1;

        // Test 1: reset held three cycles with start high -> stays IDLE at 0
        for (int i = 0; i < 3; i++) cyc("reset", 4'd0, 1'b0, 1'b0, 1'b0);
        rst        = 1'b0;
        u_if.start = 1'b0;
        cyc("idle_after_reset", 4'd0, 1'b0, 1'b0, 1'b0);

        // Test 2: start pulse, count up a full decade at one step per 4 cycles
        u_if.start = 1'b1;
        cyc("start", 4'd0, 1'b0, 1'b0, 1'b1);
        u_if.start = 1'b0;
        exp_cnt = 4'd0;
        for (int k = 1; k <= 40; k++) begin
            exp_cy = 1'b0;
            if (k % 4 == 0) begin
                exp_cnt = (exp_cnt == 4'd9) ? 4'd0 : 4'(exp_cnt + 4'd1);
                exp_cy  = (exp_cnt == 4'd0);
            end
            cyc("count_up", exp_cnt, exp_cy, 1'b0, 1'b1);
        end

        // Test 3: count down from 0 wraps to 9 with carry, dec=0x200, A..D=1001
        u_if.up_dn = 1'b0;
        for (int k = 1; k <= 3; k++) cyc("down_wait", 4'd0, 1'b0, 1'b0, 1'b1);
        cyc("down_wrap", 4'd9, 1'b1, 1'b0, 1'b1);

        // Test 4: load 7 at presc=2, next step 4 cycles later; illegal load flags err
        u_if.up_dn = 1'b1;
        cyc("pre_load", 4'd9, 1'b0, 1'b0, 1'b1);
        cyc("pre_load", 4'd9, 1'b0, 1'b0, 1'b1);
        u_if.load     = 1'b1;
        u_if.load_val = 4'd7;
        cyc("load7", 4'd7, 1'b0, 1'b0, 1'b1);
        u_if.load = 1'b0;
        for (int k = 1; k <= 3; k++) cyc("after_load", 4'd7, 1'b0, 1'b0, 1'b1);
        cyc("step_after_load", 4'd8, 1'b0, 1'b0, 1'b1);
        u_if.load     = 1'b1;
        u_if.load_val = 4'd12;
        cyc("load_bad", 4'd8, 1'b0, 1'b1, 1'b1);
        u_if.load = 1'b0;
        for (int k = 1; k <= 3; k++) cyc("after_bad", 4'd8, 1'b0, 1'b0, 1'b1);
        cyc("step_after_bad", 4'd9, 1'b0, 1'b0, 1'b1);

        // Test 5: pause at presc=2 with start and stop both high, resume restarts presc
        cyc("pre_pause", 4'd9, 1'b0, 1'b0, 1'b1);
        cyc("pre_pause", 4'd9, 1'b0, 1'b0, 1'b1);
        u_if.start = 1'b1;
        u_if.stop  = 1'b1;
        for (int k = 0; k < 20; k++) cyc("paused", 4'd9, 1'b0, 1'b0, 1'b0);
        u_if.stop = 1'b0;
        cyc("resume", 4'd9, 1'b0, 1'b0, 1'b1);
        u_if.start = 1'b0;
        for (int k = 1; k <= 3; k++) cyc("after_resume", 4'd9, 1'b0, 1'b0, 1'b1);
        cyc("resume_wrap", 4'd0, 1'b1, 1'b0, 1'b1);

        // Test 6: run up to 5, then reset while running
        exp_cnt = 4'd0;
        for (int k = 1; k <= 20; k++) begin
            if (k % 4 == 0) exp_cnt = 4'(exp_cnt + 4'd1);
            cyc("run_to_5", exp_cnt, 1'b0, 1'b0, 1'b1);
        end
        rst = 1'b1;
        cyc("rst_in_run", 4'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) cyc("idle_after_rst", 4'd0, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
